// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: transmit-side control core of the UART.
//
// Accepts one byte at a time into a holding register over a valid/ready handshake. It serialises
// each frame as a start bit, DATA_BITS data bits (LSB first), an optional parity bit and STOP_BITS
// stop bits. The core advances only on baud strobes from the baudrate generator.
//
// The state register and the data-bit counter are triplicated and majority-voted. The state
// encoding is one-hot and matches the Rx core.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-low reset
//   BaudSig_i        one-clk pulse per bit period
//   p_ParityEnable_i 1 = parity bit sent (sampled at frame start)
//   p_ParityOdd_i    1 = odd parity, 0 = even (sampled at frame start)
//   TxData_i         byte to send; bits above DATA_BITS-1 ignored
//   TxValid_i        byte offered
//   TxReady_o        holding register empty
//   Tx_o             serial line, registered, idle high
//   State_o          voted one-hot state
//   BitCounter_o     voted data-bit index (0 outside DATABITS)
//   TxDone_o         one-clk pulse at end of last stop bit
module uart_tx_fsm #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BaudSig_i,
  input  logic       p_ParityEnable_i,
  input  logic       p_ParityOdd_i,
  input  logic [7:0] TxData_i,
  input  logic       TxValid_i,
  output logic       TxReady_o,
  output logic       Tx_o,
  output logic [4:0] State_o,
  output logic [3:0] BitCounter_o,
  output logic       TxDone_o
);

  typedef enum logic [4:0] {
    StInterval  = 5'b00001,
    StStartBit  = 5'b00010,
    StDataBits  = 5'b00100,
    StParityBit = 5'b01000,
    StStopBit   = 5'b10000
  } tx_state_e;

  localparam logic [7:0] DataMask = 8'((1 << DATA_BITS) - 1);
  localparam logic [3:0] LastBit  = 4'(DATA_BITS - 1);
  localparam logic [1:0] LastStop = 2'(STOP_BITS - 1);

  // Triplicated state and counter copies; the copies are plain vectors so that an upset
  // copy can hold any pattern, legal or not.
  logic [4:0] state_a_q, state_b_q, state_c_q;
  logic [4:0] state_v, state_d;
  logic [3:0] cnt_a_q, cnt_b_q, cnt_c_q;
  logic [3:0] cnt_v, cnt_d;

  logic [1:0] stop_q, stop_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_en_q, parity_en_d;
  logic       parity_bit_q, parity_bit_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       accept;

  // Bitwise majority: any single bad copy is outvoted.
  assign state_v = (state_a_q & state_b_q) | (state_b_q & state_c_q) | (state_a_q & state_c_q);
  assign cnt_v   = (cnt_a_q & cnt_b_q) | (cnt_b_q & cnt_c_q) | (cnt_a_q & cnt_c_q);

  assign accept = TxValid_i & ~hold_full_q;

  always_comb begin
    state_d      = state_v;
    cnt_d        = cnt_v;
    stop_d       = stop_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    parity_en_d  = parity_en_q;
    parity_bit_d = parity_bit_q;
    tx_d         = tx_q;
    done_d       = 1'b0;

    // An accept can never coincide with the transfer below: the transfer needs a full
    // holding register, the accept needs an empty one.
    if (accept) begin
      hold_d      = TxData_i & DataMask;
      hold_full_d = 1'b1;
    end

    unique case (state_v)
      StInterval: begin
        cnt_d  = '0;
        stop_d = '0;
        if (BaudSig_i && hold_full_q) begin
          state_d      = StStartBit;
          tx_d         = 1'b0;
          shift_d      = hold_q;
          hold_full_d  = 1'b0;
          // Parity is fixed for the whole frame from the config seen at frame start.
          parity_en_d  = p_ParityEnable_i;
          parity_bit_d = (^hold_q) ^ p_ParityOdd_i;
        end
      end

      StStartBit: begin
        cnt_d = '0;
        if (BaudSig_i) begin
          state_d = StDataBits;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      StDataBits: begin
        if (BaudSig_i) begin
          // >= rather than == so a multi-copy counter upset still ends the frame.
          if (cnt_v >= LastBit) begin
            cnt_d  = '0;
            stop_d = '0;
            if (parity_en_q) begin
              state_d = StParityBit;
              tx_d    = parity_bit_q;
            end else begin
              state_d = StStopBit;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_v + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      StParityBit: begin
        cnt_d = '0;
        if (BaudSig_i) begin
          state_d = StStopBit;
          tx_d    = 1'b1;
          stop_d  = '0;
        end
      end

      StStopBit: begin
        cnt_d = '0;
        if (BaudSig_i) begin
          if (stop_q >= LastStop) begin
            state_d = StInterval;
            stop_d  = '0;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end
      end

      default: begin
        // Voted state is not one-hot: abandon the frame but keep any queued byte.
        state_d = StInterval;
        cnt_d   = '0;
        stop_d  = '0;
        tx_d    = 1'b1;
        shift_d = '0;
      end
    endcase
  end

  // All three copies are rewritten every clock, which scrubs a single-copy upset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_a_q    <= StInterval;
      state_b_q    <= StInterval;
      state_c_q    <= StInterval;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      cnt_c_q      <= '0;
      stop_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_a_q    <= state_d;
      state_b_q    <= state_d;
      state_c_q    <= state_d;
      cnt_a_q      <= cnt_d;
      cnt_b_q      <= cnt_d;
      cnt_c_q      <= cnt_d;
      stop_q       <= stop_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      parity_en_q  <= parity_en_d;
      parity_bit_q <= parity_bit_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
    end
  end

  assign TxReady_o    = ~hold_full_q;
  assign Tx_o         = tx_q;
  assign State_o      = state_v;
  assign BitCounter_o = cnt_v;
  assign TxDone_o     = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: an 8N1 instance (parity configurable) and a 7-data/2-stop instance.
// Frames are decoded from the serial line at mid-bit like a receiver and compared to frames
// built from the byte, parity config and frame format.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud;
  logic       par_en;
  logic       par_odd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       tx_done;
  logic [4:0] state;
  logic [3:0] bit_cnt;

  logic [7:0] tx_data72;
  logic       tx_valid72;
  logic       tx_ready72;
  logic       tx_line72;
  logic       tx_done72;
  logic [4:0] state72;
  logic [3:0] bit_cnt72;

  int  checks   = 0;
  int  failures = 0;
  int  done_cnt = 0;
  time done72_t = 0;

  always #5 clk = ~clk;

  uart_tx_fsm #(
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .BaudSig_i        (baud),
    .p_ParityEnable_i (par_en),
    .p_ParityOdd_i    (par_odd),
    .TxData_i         (tx_data),
    .TxValid_i        (tx_valid),
    .TxReady_o        (tx_ready),
    .Tx_o             (tx_line),
    .State_o          (state),
    .BitCounter_o     (bit_cnt),
    .TxDone_o         (tx_done)
  );

  uart_tx_fsm #(
    .DATA_BITS(7),
    .STOP_BITS(2)
  ) u_dut72 (
    .clk              (clk),
    .rst              (rst),
    .BaudSig_i        (baud),
    .p_ParityEnable_i (1'b0),
    .p_ParityOdd_i    (1'b0),
    .TxData_i         (tx_data72),
    .TxValid_i        (tx_valid72),
    .TxReady_o        (tx_ready72),
    .Tx_o             (tx_line72),
    .State_o          (state72),
    .BitCounter_o     (bit_cnt72),
    .TxDone_o         (tx_done72)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Baud strobe every 16 clocks, plus line monitors. Any line transition must follow a
  // clock edge at which the strobe was high.
  initial begin
    logic tx_last;
    logic tx_last72;
    logic rst_last;
    int   bcnt;
    baud      = 1'b0;
    bcnt      = 0;
    tx_last   = 1'b1;
    tx_last72 = 1'b1;
    rst_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && rst_last && tx_line !== tx_last) check_eq("tx_edge_on_baud", 32'(baud), 1);
      if (rst && rst_last && tx_line72 !== tx_last72)
        check_eq("tx72_edge_on_baud", 32'(baud), 1);
      if (tx_done) done_cnt++;
      if (tx_done72) done72_t = $time;
      tx_last   = tx_line;
      tx_last72 = tx_line72;
      rst_last  = rst;
      bcnt      = (bcnt == 15) ? 0 : bcnt + 1;
      baud      = (bcnt == 15);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit reached");
  end

  // Offer a byte at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready_wait", 32'(n < 400), 1);
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("ready_drop", 32'(tx_ready), 0);
  endtask

  // Receive one frame from the 8-bit instance and compare line, state and counter mid-bit.
  task automatic rx_frame(input logic [7:0] d, input logic pen, input logic podd,
                          input string tag, output time t_start);
    logic       exp_bit[$];
    logic [4:0] exp_st[$];
    logic [3:0] exp_cnt[$];
    int n = 0;
    int hi = 0;
    int done0;
    exp_bit.push_back(1'b0);
    exp_st.push_back(5'b00010);
    exp_cnt.push_back(4'd0);
    for (int i = 0; i < 8; i++) begin
      exp_bit.push_back(d[i]);
      exp_st.push_back(5'b00100);
      exp_cnt.push_back(4'(i));
    end
    if (pen) begin
      exp_bit.push_back((^d) ^ podd);
      exp_st.push_back(5'b01000);
      exp_cnt.push_back(4'd0);
    end
    exp_bit.push_back(1'b1);
    exp_st.push_back(5'b10000);
    exp_cnt.push_back(4'd0);

    while (tx_line !== 1'b0 && n < 4000) begin
      if (tx_ready) hi++;
      @(negedge clk);
      n++;
    end
    t_start = $time;
    check_eq({tag, "_start"}, 32'(n < 4000), 1);
    if (n >= 4000) return;
    check_eq({tag, "_ready_low_until_start"}, hi, 0);
    check_eq({tag, "_ready_at_start"}, 32'(tx_ready), 1);
    done0 = done_cnt;
    repeat (8) @(negedge clk);
    for (int i = 0; i < exp_bit.size(); i++) begin
      if (i != 0) repeat (16) @(negedge clk);
      check_eq({tag, "_bit"}, 32'(tx_line), 32'(exp_bit[i]));
      check_eq({tag, "_state"}, 32'(state), 32'(exp_st[i]));
      check_eq({tag, "_bitcnt"}, 32'(bit_cnt), 32'(exp_cnt[i]));
    end
    repeat (9) @(negedge clk);
    check_eq({tag, "_done_once"}, done_cnt - done0, 1);
  endtask

  initial begin
    time        t1;
    time        t2;
    logic [7:0] d;
    logic       eb;
    int         n;
    int         mx;
    int         j;

    rst        = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    par_en     = 1'b0;
    par_odd    = 1'b0;
    tx_valid72 = 1'b0;
    tx_data72  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state), 32'h01);
    check_eq("rst_bitcnt", 32'(bit_cnt), 0);
    check_eq("rst_tx", 32'(tx_line), 1);
    check_eq("rst_ready", 32'(tx_ready), 1);
    check_eq("rst_done", 32'(tx_done), 0);
    check_eq("rst_state72", 32'(state72), 32'h01);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    send(8'hA5);
    rx_frame(8'hA5, 1'b0, 1'b0, "a5", t1);

    // Parity: even then odd, with the odd/even select flipped mid-frame
    par_en  = 1'b1;
    par_odd = 1'b0;
    send(8'h07);
    fork
      rx_frame(8'h07, 1'b1, 1'b0, "par_even", t1);
      begin
        repeat (60) @(negedge clk);
        par_odd = 1'b1;
      end
    join
    send(8'h07);
    fork
      rx_frame(8'h07, 1'b1, 1'b1, "par_odd", t1);
      begin
        repeat (60) @(negedge clk);
        par_odd = 1'b0;
      end
    join

    // Back-to-back frames with a third offer held off
    par_en = 1'b0;
    send(8'h55);
    fork
      begin
        rx_frame(8'h55, 1'b0, 1'b0, "b2b_first", t1);
        rx_frame(8'hC3, 1'b0, 1'b0, "b2b_second", t2);
        check_eq("b2b_gap_clks", 32'((t2 - t1) / 10), 176);
      end
      begin
        repeat (40) @(negedge clk);
        check_eq("b2b_in_data", 32'(state), 32'h04);
        send(8'hC3);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        n = 0;
        while (!tx_ready && n < 400) begin
          @(negedge clk);
          n++;
        end
        // Ready only returns when the second frame's start bit begins.
        check_eq("third_held_until_start", 32'(tx_line), 0);
        tx_valid = 1'b0;
      end
    join

    // 7 data bits, 2 stop bits
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h7F : 8'($urandom);
      @(negedge clk);
      tx_valid72 = 1'b1;
      tx_data72  = d;
      @(negedge clk);
      tx_valid72 = 1'b0;
      check_eq("f72_ready_drop", 32'(tx_ready72), 0);
      n = 0;
      while (tx_line72 !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check_eq("f72_start", 32'(n < 400), 1);
      t1 = $time;
      done72_t = 0;
      mx = 0;
      for (int k = 0; k < 160; k++) begin
        if (k % 16 == 8) begin
          j = k / 16;
          if (j == 0) eb = 1'b0;
          else if (j <= 7) eb = d[j-1];
          else eb = 1'b1;
          check_eq("f72_bit", 32'(tx_line72), 32'(eb));
        end
        if (int'(bit_cnt72) > mx) mx = int'(bit_cnt72);
        @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check_eq("f72_bitcnt_peak", mx, 6);
      check_eq("f72_done_clks", 32'((done72_t - t1) / 10), 160);
    end

    // Upsets in single copies while idle, then an illegal state in all copies
    repeat (5) @(negedge clk);
    force u_dut.state_b_q = 5'b00100;
    force u_dut.cnt_a_q   = 4'd5;
    #1;
    release u_dut.state_b_q;
    release u_dut.cnt_a_q;
    check_eq("tmr_state_voted", 32'(state), 32'h01);
    check_eq("tmr_cnt_voted", 32'(bit_cnt), 0);
    check_eq("tmr_tx_idle", 32'(tx_line), 1);
    @(negedge clk);
    check_eq("tmr_copy_b_scrubbed", 32'(u_dut.state_b_q), 32'h01);
    check_eq("tmr_cnt_a_scrubbed", 32'(u_dut.cnt_a_q), 0);
    force u_dut.state_a_q = 5'b00011;
    force u_dut.state_b_q = 5'b00011;
    force u_dut.state_c_q = 5'b00011;
    #1;
    release u_dut.state_a_q;
    release u_dut.state_b_q;
    release u_dut.state_c_q;
    @(negedge clk);
    check_eq("illegal_to_interval", 32'(state), 32'h01);
    check_eq("illegal_tx_high", 32'(tx_line), 1);
    check_eq("illegal_ready", 32'(tx_ready), 1);

    // Reset in the 4th data bit
    d = 8'($urandom);
    send(d);
    n = 0;
    while (tx_line !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstmid_start", 32'(n < 400), 1);
    repeat (72) @(negedge clk);
    check_eq("rstmid_pre_state", 32'(state), 32'h04);
    check_eq("rstmid_pre_bitcnt", 32'(bit_cnt), 3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rstmid_tx", 32'(tx_line), 1);
    check_eq("rstmid_state", 32'(state), 32'h01);
    check_eq("rstmid_ready", 32'(tx_ready), 1);
    check_eq("rstmid_bitcnt", 32'(bit_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    d = 8'($urandom);
    send(d);
    rx_frame(d, 1'b0, 1'b0, "after_rst", t1);

    // Random bytes and parity configs
    for (int i = 0; i < 8; i++) begin
      par_en  = 1'($urandom_range(0, 1));
      par_odd = 1'($urandom_range(0, 1));
      d       = 8'($urandom);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      send(d);
      rx_frame(d, par_en, par_odd, "rand", t1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
